// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and flush-to-kill helper for the stall pipeline (optional counters: PIPE_PERF_EN)
package pipe_pkg;

  localparam int PIPE_STAGES_DEF = 3;
  localparam int PIPE_DW_DEF     = 64;
  localparam int PIPE_CNT_W_DEF  = 32;
  // Widest chain kill_mask can describe; flush vectors are zero-extended to this width.
  localparam int PIPE_MAX_STAGES = 32;

  // Suffix-OR: bit i is set when any flush bit at index >= i is set, so an
  // older flush also kills every younger stage.
  function automatic logic [PIPE_MAX_STAGES-1:0] kill_mask(input logic [PIPE_MAX_STAGES-1:0] flush);
    logic [PIPE_MAX_STAGES-1:0] m;
    logic                       acc;
    m   = '0;
    acc = 1'b0;
    for (int i = PIPE_MAX_STAGES - 1; i >= 0; i--) begin
      acc  = acc | flush[i];
      m[i] = acc;
    end
    return m;
  endfunction

endpackage

// File: rtl/stall_pipe_stage.sv
// rtl/stall_pipe_stage.sv - one valid/allow_in pipeline stage with payload and optional stall counter (PIPE_PERF_EN)
module stall_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DW    = PIPE_DW_DEF,
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_src_valid,
  input  logic             i_ready_go,
  input  logic             i_allow_next,
  input  logic             i_kill,
  input  logic [DW-1:0]    i_d,
  output logic             o_valid,
  output logic [DW-1:0]    o_q,
  output logic             o_allow_in,
  output logic             o_go,
  output logic             o_fire,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic          r_valid;
  logic [DW-1:0] r_q;

  // Handshake terms; allow_in depends on the older stage so a stall ripples back in the same cycle.
  assign o_go       = r_valid & i_ready_go;
  assign o_allow_in = ~r_valid | (i_ready_go & i_allow_next);
  assign o_fire     = i_src_valid & o_allow_in & ~i_kill;
  assign o_valid    = r_valid;
  assign o_q        = r_q;

  // Valid bit: a kill beats everything, otherwise take the source valid whenever we may accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (o_allow_in) begin
      r_valid <= i_src_valid;
    end
  end

  // Payload loads only when an item actually enters; killed stages keep their old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (o_fire) begin
      r_q <= i_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall     = r_valid & ~(i_ready_go & i_allow_next) & ~i_kill;
  assign o_stall_cnt = r_stall_cnt;

  // Saturating count of cycles this stage holds an item it cannot pass on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: rtl/stall_pipe_chain.sv
// rtl/stall_pipe_chain.sv - N-stage valid/allow_in pipeline with youngest-side flush (optional counters: PIPE_PERF_EN)
module stall_pipe_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES_DEF,
  parameter int DW     = PIPE_DW_DEF,
  parameter int CNT_W  = PIPE_CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    validin,
  output logic                    in_allow,
  input  logic [STAGES*DW-1:0]    stage_d,
  output logic [STAGES*DW-1:0]    stage_q,
  output logic [STAGES-1:0]       stage_valid,
  input  logic [STAGES-1:0]       ready_go,
  output logic [STAGES-1:0]       stage_fire,
  input  logic [STAGES-1:0]       flush,
  input  logic                    out_allow,
  output logic                    validout,
  output logic [STAGES*CNT_W-1:0] perf_stall
);

  logic [STAGES:0]          w_allow;
  logic [STAGES-1:0]        w_go;
  logic [STAGES-1:0]        w_src_valid;
  logic [STAGES-1:0]        w_kill;
  logic [PIPE_MAX_STAGES-1:0] w_flush_ext;

  // Zero-extend flush so the fixed-width package helper can build the kill mask.
  always_comb begin
    w_flush_ext              = '0;
    w_flush_ext[STAGES-1:0]  = flush;
  end

  assign w_kill          = STAGES'(kill_mask(w_flush_ext));
  assign w_allow[STAGES] = out_allow;
  assign in_allow        = w_allow[0];
  assign validout        = w_go[STAGES-1];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_src_valid[gi] = validin;
      end else begin : g_body
        assign w_src_valid[gi] = w_go[gi-1];
      end

      stall_pipe_stage #(
        .DW    (DW),
        .CNT_W (CNT_W)
      ) u_stage (
        .clk          (clk),
        .rst          (rst),
        .i_src_valid  (w_src_valid[gi]),
        .i_ready_go   (ready_go[gi]),
        .i_allow_next (w_allow[gi+1]),
        .i_kill       (w_kill[gi]),
        .i_d          (stage_d[gi*DW +: DW]),
        .o_valid      (stage_valid[gi]),
        .o_q          (stage_q[gi*DW +: DW]),
        .o_allow_in   (w_allow[gi]),
        .o_go         (w_go[gi]),
        .o_fire       (stage_fire[gi]),
        .o_stall_cnt  (perf_stall[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_stall_pipe_chain.sv
// tb/tb_stall_pipe_chain.sv - directed self-checking bench for stall_pipe_chain (3-stage and 1-stage builds; PIPE_PERF_EN aware)
module tb_stall_pipe_chain;

  localparam int S  = 3;
  localparam int DW = 64;
  localparam int CW = 32;

`ifdef PIPE_PERF_EN
  localparam logic [CW-1:0] EXP_STALL4 = 32'd4;
`else
  localparam logic [CW-1:0] EXP_STALL4 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              validin = 1'b0;
  logic              in_allow;
  logic [DW-1:0]     d0 = '0;
  logic [S*DW-1:0]   stage_d;
  logic [S*DW-1:0]   stage_q;
  logic [S-1:0]      stage_valid;
  logic [S-1:0]      ready_go = '0;
  logic [S-1:0]      stage_fire;
  logic [S-1:0]      flush = '0;
  logic              out_allow = 1'b0;
  logic              validout;
  logic [S*CW-1:0]   perf_stall;

  logic              v1 = 1'b0;
  logic              in_allow1;
  logic [7:0]        d1 = '0;
  logic [7:0]        q1;
  logic [0:0]        sv1;
  logic [0:0]        rg1 = '0;
  logic [0:0]        fire1;
  logic [0:0]        fl1 = '0;
  logic              oa1 = 1'b0;
  logic              validout1;
  logic [CW-1:0]     perf1;

  int errors = 0;
  int checks = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Stage 0 takes bench data; later stages pass the previous stage's payload through unchanged.
  assign stage_d[DW-1:0] = d0;
  for (genvar gi = 1; gi < S; gi++) begin : g_pass
    assign stage_d[gi*DW +: DW] = stage_q[(gi-1)*DW +: DW];
  end

  stall_pipe_chain #(.STAGES(S), .DW(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .validin(validin), .in_allow(in_allow),
    .stage_d(stage_d), .stage_q(stage_q), .stage_valid(stage_valid),
    .ready_go(ready_go), .stage_fire(stage_fire), .flush(flush),
    .out_allow(out_allow), .validout(validout), .perf_stall(perf_stall)
  );

  stall_pipe_chain #(.STAGES(1), .DW(8), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .validin(v1), .in_allow(in_allow1),
    .stage_d(d1), .stage_q(q1), .stage_valid(sv1),
    .ready_go(rg1), .stage_fire(fire1), .flush(fl1),
    .out_allow(oa1), .validout(validout1), .perf_stall(perf1)
  );

  function automatic logic [DW-1:0] qs(input int i);
    return stage_q[i*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] ps(input int i);
    return perf_stall[i*CW +: CW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL rst_valid got=%b exp=000", stage_valid); end
    checks++; if (stage_q !== '0) begin errors++; $display("FAIL rst_q got=%h exp=0", stage_q); end
    checks++; if (in_allow !== 1'b1) begin errors++; $display("FAIL rst_in_allow got=%b exp=1", in_allow); end
    checks++; if (validout !== 1'b0) begin errors++; $display("FAIL rst_validout got=%b exp=0", validout); end
    checks++; if (stage_fire !== 3'b000) begin errors++; $display("FAIL rst_fire got=%b exp=000", stage_fire); end
    checks++; if (perf_stall !== '0) begin errors++; $display("FAIL rst_perf got=%h exp=0", perf_stall); end
    tick;
    tick;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream;
    ready_go = 3'b111; out_allow = 1'b1; flush = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      validin = 1'b1; d0 = 64'(k); #1;
      checks++; if (in_allow !== 1'b1) begin errors++; $display("FAIL stream_in_allow k=%0d got=%b exp=1", k, in_allow); end
      tick;
      if (k >= 3) begin
        checks++; if (validout !== 1'b1) begin errors++; $display("FAIL stream_validout k=%0d got=%b exp=1", k, validout); end
        checks++; if (qs(2) !== 64'(k - 2)) begin errors++; $display("FAIL stream_q2 k=%0d got=%0d exp=%0d", k, qs(2), k - 2); end
      end else begin
        checks++; if (validout !== 1'b0) begin errors++; $display("FAIL stream_early_validout k=%0d got=%b exp=0", k, validout); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp_q2 [4];
    exp_q2 = '{64'd5, 64'd6, 64'd7, 64'd8};
    out_allow = 1'b0; validin = 1'b1; d0 = 64'd7; #1;
    checks++; if (in_allow !== 1'b0) begin errors++; $display("FAIL bp_in_allow got=%b exp=0", in_allow); end
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if (stage_valid !== 3'b111) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=111", c, stage_valid); end
      checks++; if ({qs(2), qs(1), qs(0)} !== {64'd4, 64'd5, 64'd6}) begin
        errors++; $display("FAIL bp_frozen c=%0d got=%0d,%0d,%0d exp=4,5,6", c, qs(2), qs(1), qs(0)); end
      checks++; if (in_allow !== 1'b0) begin errors++; $display("FAIL bp_in_allow_hold c=%0d got=%b exp=0", c, in_allow); end
    end
    checks++; if (ps(2) !== EXP_STALL4) begin errors++; $display("FAIL bp_perf2 got=%0d exp=%0d", ps(2), EXP_STALL4); end
    checks++; if (ps(0) !== EXP_STALL4) begin errors++; $display("FAIL bp_perf0 got=%0d exp=%0d", ps(0), EXP_STALL4); end
    out_allow = 1'b1;
    for (int c = 0; c < 4; c++) begin
      validin = (c < 2); d0 = 64'(7 + c);
      tick;
      checks++; if (qs(2) !== exp_q2[c] || validout !== 1'b1) begin
        errors++; $display("FAIL bp_resume c=%0d got=%0d/%b exp=%0d/1", c, qs(2), validout, exp_q2[c]); end
    end
    tick;
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL bp_drained got=%b exp=000", stage_valid); end
  endtask

  task automatic test_stage_stall;
    validin = 1'b1; d0 = 64'd10; tick;
    d0 = 64'd11; tick;
    ready_go = 3'b101; d0 = 64'd12; #1;
    checks++; if (in_allow !== 1'b0) begin errors++; $display("FAIL ss_in_allow got=%b exp=0", in_allow); end
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++; if (stage_valid !== 3'b011) begin errors++; $display("FAIL ss_valid c=%0d got=%b exp=011", c, stage_valid); end
      checks++; if (qs(1) !== 64'd10 || qs(0) !== 64'd11) begin
        errors++; $display("FAIL ss_hold c=%0d got=%0d,%0d exp=10,11", c, qs(1), qs(0)); end
    end
    ready_go = 3'b111; tick;
    checks++; if (stage_valid !== 3'b111) begin errors++; $display("FAIL ss_refill_valid got=%b exp=111", stage_valid); end
    checks++; if ({qs(2), qs(1), qs(0)} !== {64'd10, 64'd11, 64'd12}) begin
      errors++; $display("FAIL ss_refill_q got=%0d,%0d,%0d exp=10,11,12", qs(2), qs(1), qs(0)); end
  endtask

  task automatic test_flush;
    ready_go = 3'b101; flush = 3'b010; validin = 1'b1; d0 = 64'd13; #1;
    checks++; if (validout !== 1'b1 || qs(2) !== 64'd10) begin
      errors++; $display("FAIL fl_out got=%b/%0d exp=1/10", validout, qs(2)); end
    checks++; if (stage_fire !== 3'b000) begin errors++; $display("FAIL fl_fire got=%b exp=000", stage_fire); end
    tick;
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL fl_valid got=%b exp=000", stage_valid); end
    flush = 3'b000; ready_go = 3'b111; validin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (validout !== 1'b0) begin errors++; $display("FAIL fl_no_leak c=%0d got=%b exp=0", c, validout); end
    end
  endtask

  task automatic test_flush_advance;
    for (int k = 20; k <= 22; k++) begin
      validin = 1'b1; d0 = 64'(k); tick;
    end
    flush = 3'b010; d0 = 64'd23; #1;
    checks++; if (stage_fire !== 3'b100) begin errors++; $display("FAIL fa_fire got=%b exp=100", stage_fire); end
    tick;
    checks++; if (stage_valid !== 3'b100 || qs(2) !== 64'd21) begin
      errors++; $display("FAIL fa_advance got=%b/%0d exp=100/21", stage_valid, qs(2)); end
    flush = 3'b000; validin = 1'b0; tick;
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL fa_drain got=%b exp=000", stage_valid); end
  endtask

  task automatic test_async_reset;
    validin = 1'b1; d0 = 64'd30; tick;
    d0 = 64'd31; tick;
    #3 rst = 1'b1;
    #1;
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL ar_valid got=%b exp=000", stage_valid); end
    checks++; if (stage_q !== '0) begin errors++; $display("FAIL ar_q got=%h exp=0", stage_q); end
    checks++; if (perf_stall !== '0) begin errors++; $display("FAIL ar_perf got=%h exp=0", perf_stall); end
    checks++; if (in_allow !== 1'b1) begin errors++; $display("FAIL ar_in_allow got=%b exp=1", in_allow); end
    tick;
    checks++; if (stage_valid !== 3'b000 || in_allow !== 1'b1) begin
      errors++; $display("FAIL ar_held got=%b/%b exp=000/1", stage_valid, in_allow); end
    @(negedge clk);
    rst = 1'b0; validin = 1'b0;
  endtask

  task automatic test_single_stage;
    v1 = 1'b1; d1 = 8'hA5; rg1 = 1'b1; oa1 = 1'b1; fl1 = 1'b0; #1;
    checks++; if (fire1 !== 1'b1) begin errors++; $display("FAIL s1_fire got=%b exp=1", fire1); end
    tick;
    checks++; if (q1 !== 8'hA5 || sv1 !== 1'b1) begin errors++; $display("FAIL s1_load got=%h/%b exp=a5/1", q1, sv1); end
    checks++; if (validout1 !== 1'b1) begin errors++; $display("FAIL s1_validout got=%b exp=1", validout1); end
    rg1 = 1'b0; #1;
    checks++; if (validout1 !== 1'b0 || in_allow1 !== 1'b0) begin
      errors++; $display("FAIL s1_rg_low got=%b/%b exp=0/0", validout1, in_allow1); end
    rg1 = 1'b1; #1;
    checks++; if (validout1 !== 1'b1) begin errors++; $display("FAIL s1_rg_high got=%b exp=1", validout1); end
    fl1 = 1'b1; d1 = 8'h3C; #1;
    checks++; if (fire1 !== 1'b0) begin errors++; $display("FAIL s1_flush_fire got=%b exp=0", fire1); end
    tick;
    checks++; if (sv1 !== 1'b0 || q1 !== 8'hA5) begin errors++; $display("FAIL s1_flush got=%b/%h exp=0/a5", sv1, q1); end
    fl1 = 1'b0; v1 = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_stage_stall;
    test_flush;
    test_flush_advance;
    test_async_reset;
    test_single_stage;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
